// File: rtl/pwm_gen_multi.sv
// pwm_gen_multi: NCH-channel PWM generator on one shared WIDTH-bit timebase,
// with preloaded (shadowed) ARR/CCR, per-channel enable and polarity.
// Latency: pwm and period_end are registered, one clock behind cnt_o.
// Backpressure: none; free-running while en=1, frozen while en=0.
// Optional build macro PWM_CENTER_ALIGN_EN adds the `center` input for
// up/down (center-aligned) counting; without it the block is edge-aligned only.
module pwm_gen_multi #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [WIDTH-1:0]     arr,
  input  logic [NCH*WIDTH-1:0] ccr,
  input  logic [NCH-1:0]       ch_en,
  input  logic [NCH-1:0]       pol,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic                 center,
`endif
  output logic [NCH-1:0]       pwm,
  output logic                 period_end,
  output logic [WIDTH-1:0]     cnt_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]     cnt;
  logic [WIDTH-1:0]     cnt_nxt;
  logic [WIDTH-1:0]     arr_act;
  logic [NCH*WIDTH-1:0] ccr_act;
  logic                 reload;
  logic                 shadow_ld;
  logic [NCH-1:0]       raw;

`ifdef PWM_CENTER_ALIGN_EN
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  dir_t dir;
  dir_t dir_nxt;
  logic center_act;

  // Next-count / direction / reload decision. In center mode the reload is
  // raised on the cycle whose successor is the valley (cnt 0), so the new
  // active set and period_end both line up with cnt_o==0. The ">=" compares
  // keep the counter bounded even if arr_act was lowered while en=0.
  always_comb begin
    reload  = 1'b0;
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (center_act) begin
      if (dir == DIR_UP) begin
        if (cnt >= arr_act) begin
          if (arr_act <= ONE) begin
            // arr 0 or 1: peak and valley coincide, wrap straight to 0
            reload  = 1'b1;
            cnt_nxt = '0;
            dir_nxt = DIR_UP;
          end else begin
            cnt_nxt = cnt - ONE;
            dir_nxt = DIR_DOWN;
          end
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end else begin
        if (cnt <= ONE) begin
          reload  = 1'b1;
          cnt_nxt = '0;
          dir_nxt = DIR_UP;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
    end else begin
      dir_nxt = DIR_UP;
      if (cnt >= arr_act) begin
        reload  = 1'b1;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt + ONE;
      end
    end
  end

  // Timebase state: counter and count direction, held while en=0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else if (en) begin
      cnt <= cnt_nxt;
      dir <= dir_nxt;
    end
  end

  // Mode select is shadowed like ARR/CCR so a switch never cuts a period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      center_act <= 1'b0;
    end else if (shadow_ld) begin
      center_act <= center;
    end
  end
`else
  // Edge-aligned wrap decision; ">=" keeps the counter bounded even if
  // arr_act was lowered below cnt while the timebase was stopped.
  always_comb begin
    reload  = (cnt >= arr_act);
    cnt_nxt = reload ? '0 : (cnt + ONE);
  end

  // Timebase counter, held while en=0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt_nxt;
    end
  end
`endif

  // Shadows follow the CPU registers while stopped, and only take new
  // values on a reload while running, so a period is never truncated.
  assign shadow_ld = !en || reload;

  // Active ARR/CCR set used by the counter and comparators.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arr_act <= '0;
      ccr_act <= '0;
    end else if (shadow_ld) begin
      arr_act <= arr;
      ccr_act <= ccr;
    end
  end

  // Per-channel unsigned compare; ccr >= arr gives 100% duty.
  for (genvar i = 0; i < NCH; i++) begin : g_cmp
    assign raw[i] = (cnt <= ccr_act[i*WIDTH +: WIDTH]);
  end

  // Output stage: polarity applied, disabled channels park at inactive level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm        <= '0;
      period_end <= 1'b0;
    end else begin
      pwm        <= (ch_en & (raw ^ pol)) | (~ch_en & pol);
      period_end <= en && reload;
    end
  end

  assign cnt_o = cnt;

endmodule

// File: tb/tb_pwm_gen_multi.sv
// Self-checking bench for pwm_gen_multi (WIDTH=8, NCH=4).
// Per-cycle expectations are queued as stimulus is applied and popped after
// each clock; scenario tasks add duty/period checks from known constants.
module tb_pwm_gen_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [7:0]  arr;
  logic [31:0] ccr;
  logic [3:0]  ch_en;
  logic [3:0]  pol;
  logic [3:0]  pwm;
  logic        period_end;
  logic [7:0]  cnt_o;
`ifdef PWM_CENTER_ALIGN_EN
  logic        center = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0] cnt;
    logic [3:0] pwm;
    logic       pe;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] m_cnt;
  logic [7:0] m_arr;
  logic [7:0] m_ccr [4];

  always #5 clk = ~clk;

  pwm_gen_multi #(.WIDTH(8), .NCH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .arr        (arr),
    .ccr        (ccr),
    .ch_en      (ch_en),
    .pol        (pol),
`ifdef PWM_CENTER_ALIGN_EN
    .center     (center),
`endif
    .pwm        (pwm),
    .period_end (period_end),
    .cnt_o      (cnt_o)
  );

  task automatic model_reset();
    m_cnt = 8'd0;
    m_arr = 8'd0;
    for (int i = 0; i < 4; i++) m_ccr[i] = 8'd0;
    sbq.delete();
  endtask

  // One clock: predict outputs from the reference state and current inputs,
  // queue them, clock, then pop and compare.
  task automatic step();
    exp_t e;
    exp_t x;
    logic rl;
    rl = (m_cnt >= m_arr);
    for (int i = 0; i < 4; i++)
      e.pwm[i] = ch_en[i] ? ((m_cnt <= m_ccr[i]) ^ pol[i]) : pol[i];
    e.pe = en & rl;
    if (en) m_cnt = rl ? 8'd0 : (m_cnt + 8'd1);
    if (!en || rl) begin
      m_arr = arr;
      for (int i = 0; i < 4; i++) m_ccr[i] = ccr[i*8 +: 8];
    end
    e.cnt = m_cnt;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    n_cmp++;
    if (cnt_o !== x.cnt) begin
      n_err++;
      $display("FAIL sb_cnt t=%0t got %0d expected %0d", $time, cnt_o, x.cnt);
    end
    n_cmp++;
    if (pwm !== x.pwm) begin
      n_err++;
      $display("FAIL sb_pwm t=%0t got %b expected %b", $time, pwm, x.pwm);
    end
    n_cmp++;
    if (period_end !== x.pe) begin
      n_err++;
      $display("FAIL sb_period_end t=%0t got %b expected %b", $time, period_end, x.pe);
    end
  endtask

  // Clock until period_end is seen; len=-1 if it never shows within limit.
  task automatic run_to_pe(input int limit, output int len, output int hi0);
    len = -1;
    hi0 = 0;
    for (int k = 1; k <= limit; k++) begin
      step();
      hi0 += int'(pwm[0]);
      if (period_end === 1'b1) begin
        len = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en    = 1'b0;
    arr   = 8'd5;
    ccr   = {8'd0, 8'd3, 8'd2, 8'd4};
    ch_en = 4'b0011;
    pol   = 4'hF;
    @(posedge clk);
    #1;
    n_cmp++;
    if (cnt_o !== 8'd0) begin n_err++; $display("FAIL reset_cnt got %0d expected 0", cnt_o); end
    n_cmp++;
    if (pwm !== 4'b0000) begin n_err++; $display("FAIL reset_pwm got %b expected 0000", pwm); end
    n_cmp++;
    if (period_end !== 1'b0) begin n_err++; $display("FAIL reset_pe got %b expected 0", period_end); end
    model_reset();
    pol   = 4'h0;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int hi0, hi1, hi23, pes, first, second;
    step();
    step();
    en = 1'b1;
    hi0 = 0; hi1 = 0; hi23 = 0; pes = 0; first = -1; second = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      hi0  += int'(pwm[0]);
      hi1  += int'(pwm[1]);
      hi23 += int'(pwm[2]) + int'(pwm[3]);
      if (period_end === 1'b1) begin
        pes++;
        if (first < 0) first = k; else second = k;
      end
    end
    n_cmp++;
    if (hi0 !== 10) begin n_err++; $display("FAIL basic_duty0 got %0d expected 10", hi0); end
    n_cmp++;
    if (hi1 !== 6) begin n_err++; $display("FAIL basic_duty1 got %0d expected 6", hi1); end
    n_cmp++;
    if (hi23 !== 0) begin n_err++; $display("FAIL basic_disabled got %0d expected 0", hi23); end
    n_cmp++;
    if (pes !== 2) begin n_err++; $display("FAIL basic_pe_count got %0d expected 2", pes); end
    n_cmp++;
    if (second - first !== 6) begin n_err++; $display("FAIL basic_period got %0d expected 6", second - first); end
  endtask

  task automatic test_shadow();
    int len, hi;
    step();
    step();
    n_cmp++;
    if (cnt_o !== 8'd2) begin n_err++; $display("FAIL shadow_align got %0d expected 2", cnt_o); end
    arr       = 8'd9;
    ccr[7:0]  = 8'd1;
    run_to_pe(20, len, hi);
    n_cmp++;
    if (len !== 4) begin n_err++; $display("FAIL shadow_cur_period got %0d expected 4", len); end
    n_cmp++;
    if (hi !== 3) begin n_err++; $display("FAIL shadow_cur_duty got %0d expected 3", hi); end
    run_to_pe(20, len, hi);
    n_cmp++;
    if (len !== 10) begin n_err++; $display("FAIL shadow_new_period got %0d expected 10", len); end
    n_cmp++;
    if (hi !== 2) begin n_err++; $display("FAIL shadow_new_duty got %0d expected 2", hi); end
  endtask

  task automatic test_polarity();
    int len, hi;
    arr      = 8'd5;
    ccr[7:0] = 8'd4;
    pol      = 4'b0001;
    run_to_pe(20, len, hi);
    n_cmp++;
    if (len !== 10) begin n_err++; $display("FAIL pol_drain got %0d expected 10", len); end
    run_to_pe(20, len, hi);
    n_cmp++;
    if (len !== 6) begin n_err++; $display("FAIL pol_period got %0d expected 6", len); end
    n_cmp++;
    if (hi !== 1) begin n_err++; $display("FAIL pol_inverted_high got %0d expected 1", hi); end
    ch_en = 4'b0010;
    run_to_pe(20, len, hi);
    n_cmp++;
    if (hi !== 6) begin n_err++; $display("FAIL pol_disabled_level got %0d expected 6", hi); end
  endtask

  task automatic test_arr_zero();
    int len, hi, pes, nz;
    pol      = 4'b0000;
    ch_en    = 4'b0011;
    arr      = 8'd0;
    ccr[7:0] = 8'd0;
    run_to_pe(20, len, hi);
    n_cmp++;
    if (len !== 6) begin n_err++; $display("FAIL arr0_drain got %0d expected 6", len); end
    hi = 0; pes = 0; nz = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      hi  += int'(pwm[0]);
      pes += int'(period_end);
      if (cnt_o !== 8'd0) nz++;
    end
    n_cmp++;
    if (pes !== 8) begin n_err++; $display("FAIL arr0_pe got %0d expected 8", pes); end
    n_cmp++;
    if (hi !== 8) begin n_err++; $display("FAIL arr0_duty got %0d expected 8", hi); end
    n_cmp++;
    if (nz !== 0) begin n_err++; $display("FAIL arr0_cnt_moved got %0d expected 0", nz); end
    arr      = 8'd5;
    ccr[7:0] = 8'd7;
    hi = 0; pes = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      hi  += int'(pwm[0]);
      pes += int'(period_end);
    end
    n_cmp++;
    if (hi !== 12) begin n_err++; $display("FAIL ccr_over_arr_duty got %0d expected 12", hi); end
    n_cmp++;
    if (pes !== 2) begin n_err++; $display("FAIL ccr_over_arr_pe got %0d expected 2", pes); end
  endtask

  task automatic test_en_freeze();
    int len, hi, moved;
    logic [7:0] held_cnt;
    logic [3:0] held_pwm;
    run_to_pe(20, len, hi);
    n_cmp++;
    if (len !== 1) begin n_err++; $display("FAIL freeze_align got %0d expected 1", len); end
    step();
    step();
    en       = 1'b0;
    held_cnt = cnt_o;
    held_pwm = pwm;
    moved    = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (cnt_o !== held_cnt || pwm !== held_pwm) moved++;
    end
    n_cmp++;
    if (moved !== 0) begin n_err++; $display("FAIL freeze_hold got %0d expected 0", moved); end
    en = 1'b1;
    run_to_pe(20, len, hi);
    n_cmp++;
    if (len !== 4) begin n_err++; $display("FAIL freeze_resume got %0d expected 4", len); end
  endtask

  task automatic test_reset_mid();
    int len, hi;
    bit found;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (cnt_o === 8'd3) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL rstmid_reach got %0d expected 3", cnt_o); end
    #2;
    reset = 1'b0;
    en    = 1'b0;
    #1;
    n_cmp++;
    if (cnt_o !== 8'd0) begin n_err++; $display("FAIL rstmid_cnt got %0d expected 0", cnt_o); end
    n_cmp++;
    if (pwm !== 4'b0000) begin n_err++; $display("FAIL rstmid_pwm got %b expected 0000", pwm); end
    n_cmp++;
    if (period_end !== 1'b0) begin n_err++; $display("FAIL rstmid_pe got %b expected 0", period_end); end
    model_reset();
    @(posedge clk);
    #1;
    n_cmp++;
    if (cnt_o !== 8'd0 || pwm !== 4'b0000) begin
      n_err++;
      $display("FAIL rstmid_held got cnt %0d pwm %b expected 0 0000", cnt_o, pwm);
    end
    reset = 1'b1;
    step();
    en = 1'b1;
    run_to_pe(20, len, hi);
    n_cmp++;
    if (len !== 6) begin n_err++; $display("FAIL rstmid_first_pe got %0d expected 6", len); end
  endtask

`ifdef PWM_CENTER_ALIGN_EN
  task automatic test_center();
    logic [7:0] c [20];
    logic       p [20];
    logic       e [20];
    logic [7:0] ref_seq [8];
    int k0, hi;
    ref_seq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1};
    sbq.delete();
    reset    = 1'b0;
    en       = 1'b0;
    center   = 1'b1;
    arr      = 8'd4;
    ccr[7:0] = 8'd1;
    ch_en    = 4'b0001;
    pol      = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      c[k] = cnt_o;
      p[k] = pwm[0];
      e[k] = period_end;
    end
    k0 = -1;
    for (int k = 0; k < 10; k++) if (k0 < 0 && e[k] === 1'b1) k0 = k;
    n_cmp++;
    if (k0 !== 7) begin n_err++; $display("FAIL center_first_pe got %0d expected 7", k0); end
    if (k0 < 0) k0 = 7;
    for (int j = 0; j < 8; j++) begin
      n_cmp++;
      if (c[k0+j] !== ref_seq[j]) begin
        n_err++;
        $display("FAIL center_cnt[%0d] got %0d expected %0d", j, c[k0+j], ref_seq[j]);
      end
    end
    hi = 0;
    for (int j = 1; j <= 8; j++) hi += int'(p[k0+j]);
    n_cmp++;
    if (hi !== 3) begin n_err++; $display("FAIL center_duty got %0d expected 3", hi); end
    n_cmp++;
    if (e[k0+8] !== 1'b1) begin n_err++; $display("FAIL center_period got %b expected 1", e[k0+8]); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_shadow();
    test_polarity();
    test_arr_zero();
    test_en_freeze();
    test_reset_mid();
`ifdef PWM_CENTER_ALIGN_EN
    test_center();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
